btn_conditioner: RTL and testbench

- Conditions the four raw, active-low board pushbuttons (up/down/left/right) before they reach the MENU block's btn_up/btn_dn/btn_lf/btn_rt inputs.
- Each button passes through a two-flop synchroniser, then a ce-timed debouncer, then a hold-to-repeat generator.
- MENU sees clean active-low levels, with a synthetic one-cycle release for each auto-repeat, so a held button steps a config value repeatedly.
- A one-cycle press strobe per button is also exported for other consumers.

---
 rtl/btn_conditioner.sv | 157 +++++++++++++++
 tb/tb_btn_conditioner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and auto-repeat active-low pushbuttons.
// Each bit is conditioned independently. MENU sees a clean active-low level with
// a one-clk synthetic release on every auto-repeat, and a press strobe is exported.
module btn_conditioner #(
    parameter int unsigned N_BTN          = 4,
    parameter int unsigned DEBOUNCE_TICKS = 8,
    parameter int unsigned REPEAT_DELAY   = 64,
    parameter int unsigned REPEAT_RATE    = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [N_BTN-1:0] btn_n_raw,
    output logic [N_BTN-1:0] btn_n_out,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] held
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_e;

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;

    // Two-flop synchroniser inputs, clocked every clk regardless of ce.
    always_comb begin
        sync1_d = btn_n_raw;
        sync2_d = sync1_q;
    end

    // Synchroniser flops; reset to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic             pressed_sync;
        logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
        logic             stable_q, stable_d;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;
        logic             rpt_c;
        logic             press_q, press_d;
        logic             held_q, held_d;
        logic             out_n_q, out_n_d;

        assign pressed_sync = ~sync2_q[i];

        // Debouncer: accept a new level after DEBOUNCE_TICKS consecutive differing ce cycles.
        always_comb begin
            db_cnt_d = db_cnt_q;
            stable_d = stable_q;
            if (pressed_sync == stable_q) begin
                db_cnt_d = '0;
            end else if (ce) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_d = ~stable_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
        end

        // Repeat FSM next state; a release always beats a repeat due on the same edge.
        always_comb begin
            state_d  = state_q;
            rp_cnt_d = rp_cnt_q;
            press_d  = 1'b0;
            rpt_c    = 1'b0;
            unique case (state_q)
                IDLE: begin
                    rp_cnt_d = '0;
                    if (stable_q) begin
                        state_d = DELAY;
                        press_d = 1'b1;
                    end
                end
                DELAY: begin
                    if (!stable_q) begin
                        state_d  = IDLE;
                        rp_cnt_d = '0;
                    end else if (ce && (REPEAT_DELAY != 0)) begin
                        if (rp_cnt_q == RD_LAST) begin
                            state_d  = REPEAT;
                            rp_cnt_d = '0;
                            press_d  = 1'b1;
                            rpt_c    = 1'b1;
                        end else begin
                            rp_cnt_d = rp_cnt_q + CNT_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (!stable_q) begin
                        state_d  = IDLE;
                        rp_cnt_d = '0;
                    end else if (ce) begin
                        if (rp_cnt_q == RR_LAST) begin
                            rp_cnt_d = '0;
                            press_d  = 1'b1;
                            rpt_c    = 1'b1;
                        end else begin
                            rp_cnt_d = rp_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    rp_cnt_d = '0;
                end
            endcase
            held_d  = (state_d != IDLE);
            out_n_d = ~held_d | rpt_c;
        end

        // Per-button state and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt_q <= '0;
                stable_q <= 1'b0;
                state_q  <= IDLE;
                rp_cnt_q <= '0;
                press_q  <= 1'b0;
                held_q   <= 1'b0;
                out_n_q  <= 1'b1;
            end else begin
                db_cnt_q <= db_cnt_d;
                stable_q <= stable_d;
                state_q  <= state_d;
                rp_cnt_q <= rp_cnt_d;
                press_q  <= press_d;
                held_q   <= held_d;
                out_n_q  <= out_n_d;
            end
        end

        assign btn_n_out[i] = out_n_q;
        assign press[i]     = press_q;
        assign held[i]      = held_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with short debounce/repeat timing.
// Edge numbers: edge b is the first rising edge that samples a raw change.
module tb_btn_conditioner;

    localparam int unsigned NB = 4;
    localparam int unsigned DT = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RR = 3;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce  = 1'b1;
    logic [NB-1:0] btn_n_raw = 4'b1111;
    logic [NB-1:0] btn_n_out;
    logic [NB-1:0] press;
    logic [NB-1:0] held;

    btn_conditioner #(
        .N_BTN(NB), .DEBOUNCE_TICKS(DT), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .btn_n_raw(btn_n_raw),
        .btn_n_out(btn_n_out), .press(press), .held(held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] bn;
        logic [3:0] held;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] bn, input logic [3:0] h);
        exp_t e;
        e.cyc = c; e.press = p; e.bn = bn; e.held = h;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %b expected %b", nm, cyc, got, exp);
        end
    endtask

    task automatic chk_lvl(input string nm, input logic [3:0] bn, input logic [3:0] h);
        chk({nm, " btn_n_out"}, btn_n_out, bn);
        chk({nm, " held"}, held, h);
    endtask

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (press !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected press=%b out=%b held=%b at edge %0d",
                         press, btn_n_out, held, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || press !== e.press || btn_n_out !== e.bn || held !== e.held) begin
                    errors++;
                    $display("FAIL strobe: got edge=%0d press=%b out=%b held=%b, expected edge=%0d press=%b out=%b held=%b",
                             cyc, press, btn_n_out, held, e.cyc, e.press, e.bn, e.held);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        // Reset state
        goto(2);
        chk_lvl("reset", 4'b1111, 4'b0000);
        chk("reset press", press, 4'b0000);
        goto(3);
        rst = 1'b0;

        // 1: idle with buttons released
        for (int k = 4; k < 24; k++) begin
            goto(k);
            chk_lvl("idle", 4'b1111, 4'b0000);
            chk("idle press", press, 4'b0000);
        end

        // 2: hold down, expect press then repeats; release lands on a due repeat
        b = cyc + 2;
        push(b + 6,  4'b0010, 4'b1101, 4'b0010);
        push(b + 16, 4'b0010, 4'b1111, 4'b0010);
        push(b + 19, 4'b0010, 4'b1111, 4'b0010);
        push(b + 22, 4'b0010, 4'b1111, 4'b0010);
        goto(b - 1); btn_n_raw[1] = 1'b0;
        goto(b + 5);  chk_lvl("down pre-accept", 4'b1111, 4'b0000);
        goto(b + 17); chk_lvl("down after repeat", 4'b1101, 4'b0010);
        goto(b + 18); btn_n_raw[1] = 1'b1;
        goto(b + 24); chk_lvl("down pre-release", 4'b1101, 4'b0010);
        goto(b + 25); chk_lvl("down released", 4'b1111, 4'b0000);
        goto(b + 30);

        // 3: 3-clk glitch rejected, 4-clk low accepted
        b = cyc + 2;
        goto(b - 1); btn_n_raw[0] = 1'b0;
        goto(b + 2); btn_n_raw[0] = 1'b1;
        goto(b + 8); chk_lvl("glitch", 4'b1111, 4'b0000);
        b = cyc + 2;
        push(b + 6, 4'b0001, 4'b1110, 4'b0001);
        goto(b - 1); btn_n_raw[0] = 1'b0;
        goto(b + 3); btn_n_raw[0] = 1'b1;
        goto(b + 9);  chk_lvl("short press held", 4'b1110, 4'b0001);
        goto(b + 10); chk_lvl("short press released", 4'b1111, 4'b0000);
        goto(b + 16);

        // 4: ce alternating 1,0 -- left button, all timing in ce cycles
        b = cyc + 2;
        push(b + 9,  4'b0100, 4'b1011, 4'b0100);
        push(b + 28, 4'b0100, 4'b1111, 4'b0100);
        push(b + 34, 4'b0100, 4'b1111, 4'b0100);
        for (int k = 0; k <= 41; k++) begin
            goto(b + k - 1);
            if (k == 9)  chk_lvl("ce pre-accept", 4'b1111, 4'b0000);
            if (k == 30) chk_lvl("ce after repeat", 4'b1011, 4'b0100);
            if (k == 39) chk_lvl("ce pre-release", 4'b1011, 4'b0100);
            if (k == 40) chk_lvl("ce released", 4'b1111, 4'b0000);
            ce = ((k % 2) == 0);
            if (k == 0)  btn_n_raw[2] = 1'b0;
            if (k == 30) btn_n_raw[2] = 1'b1;
        end
        ce = 1'b1;
        goto(b + 46);

        // 5: up and right together, then up released while right keeps repeating
        b = cyc + 2;
        push(b + 6,  4'b1001, 4'b0110, 4'b1001);
        push(b + 16, 4'b1001, 4'b1111, 4'b1001);
        push(b + 19, 4'b1001, 4'b1111, 4'b1001);
        push(b + 22, 4'b1001, 4'b1111, 4'b1001);
        push(b + 25, 4'b1000, 4'b1111, 4'b1000);
        push(b + 28, 4'b1000, 4'b1111, 4'b1000);
        goto(b - 1);  btn_n_raw = 4'b0110;
        goto(b + 16); btn_n_raw[0] = 1'b1;
        goto(b + 23); chk_lvl("right alone", 4'b0111, 4'b1000);
        goto(b + 24); btn_n_raw[3] = 1'b1;
        goto(b + 29); chk_lvl("right repeating", 4'b0111, 4'b1000);
        goto(b + 31); chk_lvl("right released", 4'b1111, 4'b0000);
        goto(b + 36);

        // 6: reset pulse while down is repeating and still held
        b = cyc + 2;
        push(b + 6,  4'b0010, 4'b1101, 4'b0010);
        push(b + 16, 4'b0010, 4'b1111, 4'b0010);
        push(b + 19, 4'b0010, 4'b1111, 4'b0010);
        push(b + 27, 4'b0010, 4'b1101, 4'b0010);
        goto(b - 1);  btn_n_raw[1] = 1'b0;
        goto(b + 19); rst = 1'b1;
        goto(b + 20);
        chk_lvl("mid reset", 4'b1111, 4'b0000);
        chk("mid reset press", press, 4'b0000);
        rst = 1'b0;
        goto(b + 26); chk_lvl("re-debounce", 4'b1111, 4'b0000);
        goto(b + 27); btn_n_raw[1] = 1'b1;
        goto(b + 34); chk_lvl("post-reset release", 4'b1111, 4'b0000);
        goto(b + 40);

        // Every expected strobe must have been seen
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing strobes: %0d expected strobes never seen, next at edge %0d",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
